// File: rtl/regfile_pkg.sv
// Shared defaults and the byte-merge helper for the multi-port register file.
// byte_merge works on the widest supported word; callers zero-extend and truncate.
package regfile_pkg;

  localparam int DEF_XLEN     = 32;
  localparam int DEF_NREGS    = 32;
  localparam int DEF_LINK_REG = 31;
  localparam int DEF_SYS_REG  = 2;

  localparam int MAX_XLEN = 128;
  localparam int MAX_NB   = MAX_XLEN / 8;

  function automatic logic [MAX_XLEN-1:0] byte_merge(
    input logic [MAX_XLEN-1:0] old_w,
    input logic [MAX_XLEN-1:0] data_w,
    input logic [MAX_NB-1:0]   be
  );
    logic [MAX_XLEN-1:0] res;
    res = old_w;
    for (int b = 0; b < MAX_NB; b++) begin
      if (be[b]) res[b*8 +: 8] = data_w[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/regfile_mp_scoreboard.sv
// Per-register pending-write counters: issue increments, commits decrement,
// result clamped to [0, max]. Produces issue-ready and per-read-port busy.
module reg_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS    = DEF_NREGS,
  parameter int CNT_W    = 2,
  parameter int NREAD    = 2,
  parameter int LINK_REG = DEF_LINK_REG,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic             lk_en_i,
  input  logic             iss_valid_i,
  input  logic [AW-1:0]    iss_addr_i,
  input  logic [NREAD*AW-1:0] rd_addr_i,
  output logic             iss_ready_o,
  output logic [NREAD-1:0] rd_busy_o
);

  localparam logic [AW-1:0]    LINK_A  = AW'(LINK_REG);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam int               EW      = CNT_W + 2;

  logic [CNT_W-1:0] w_cnt     [NREGS];
  logic [1:0]       w_commits [NREGS];
  logic             w_iss_acc;

  // Readiness looks at registered counts only; a same-cycle commit does not help.
  assign iss_ready_o = (iss_addr_i == '0) || (w_cnt[iss_addr_i] != CNT_MAX);
  assign w_iss_acc   = iss_valid_i && iss_ready_o && (iss_addr_i != '0);

  for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
    if (gi == 0) begin : g_zero
      assign w_cnt[gi]     = '0;
      assign w_commits[gi] = 2'd0;
    end else begin : g_cnt
      logic [CNT_W-1:0] r_cnt;
      logic [CNT_W-1:0] w_next;
      logic [EW-1:0]    w_up;
      logic [EW-1:0]    w_dn;

      assign w_commits[gi] = {1'b0, wr_en_i && (wr_addr_i == AW'(gi))}
                           + {1'b0, lk_en_i && (LINK_A == AW'(gi))};
      assign w_up = {2'b00, r_cnt} + EW'(w_iss_acc && (iss_addr_i == AW'(gi)));
      assign w_dn = EW'(w_commits[gi]);

      always_comb begin
        w_next = '0;
        if (w_up <= w_dn)                       w_next = '0;
        else if ((w_up - w_dn) > EW'(CNT_MAX))  w_next = CNT_MAX;
        else                                    w_next = CNT_W'(w_up - w_dn);
      end

      always_ff @(posedge clk) begin
        if (rst) r_cnt <= '0;
        else     r_cnt <= w_next;
      end

      assign w_cnt[gi] = r_cnt;
    end
  end

  for (genvar gi = 0; gi < NREAD; gi++) begin : g_busy
    logic [AW-1:0] w_a;
    assign w_a = rd_addr_i[gi*AW +: AW];
    assign rd_busy_o[gi] = (w_a != '0) &&
                           ({2'b00, w_cnt[w_a]} > EW'(w_commits[w_a]));
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: byte-merge WriteBack port, link port, bypassed
// reads and a pending-write scoreboard for Decode hazard stalls.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN     = DEF_XLEN,
  parameter int NREGS    = DEF_NREGS,
  parameter int NREAD    = 2,
  parameter int CNT_W    = 2,
  parameter int LINK_REG = DEF_LINK_REG,
  parameter int SYS_REG  = DEF_SYS_REG,
  localparam int AW      = $clog2(NREGS),
  localparam int NB      = XLEN / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREAD*AW-1:0]   rd_addr_i,
  output logic [NREAD*XLEN-1:0] rd_data_o,
  output logic [NREAD-1:0]      rd_busy_o,
  input  logic                  wr_en_i,
  input  logic [AW-1:0]         wr_addr_i,
  input  logic [NB-1:0]         wr_be_i,
  input  logic [XLEN-1:0]       wr_data_i,
  input  logic                  lk_en_i,
  input  logic [XLEN-1:0]       lk_data_i,
  input  logic                  iss_valid_i,
  input  logic [AW-1:0]         iss_addr_i,
  output logic                  iss_ready_o,
  output logic [XLEN-1:0]       sys_o
);

  localparam logic [AW-1:0] LINK_A = AW'(LINK_REG);
  localparam logic [AW-1:0] SYS_A  = AW'(SYS_REG);

  logic [XLEN-1:0] r_regs [NREGS];
  logic            w_wr_hit;
  logic            w_lk_hit;
  logic [XLEN-1:0] w_base;
  logic [XLEN-1:0] w_wr_val;

  assign w_wr_hit = wr_en_i && (wr_addr_i != '0);
  assign w_lk_hit = lk_en_i && (LINK_A != '0);

  // On a link collision port 0 merges over the fresh link value, so its bytes win.
  assign w_base   = (w_lk_hit && (wr_addr_i == LINK_A)) ? lk_data_i : r_regs[wr_addr_i];
  assign w_wr_val = XLEN'(byte_merge(MAX_XLEN'(w_base), MAX_XLEN'(wr_data_i),
                                     MAX_NB'(wr_be_i)));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else begin
      if (w_lk_hit) r_regs[LINK_A]    <= lk_data_i;
      if (w_wr_hit) r_regs[wr_addr_i] <= w_wr_val;
    end
  end

  // Read ports plus the SYS tap (index NREAD) share one bypass rule.
  for (genvar gi = 0; gi <= NREAD; gi++) begin : g_rd
    logic [AW-1:0]   w_a;
    logic [XLEN-1:0] w_val;

    if (gi < NREAD) begin : g_port
      assign w_a = rd_addr_i[gi*AW +: AW];
      assign rd_data_o[gi*XLEN +: XLEN] = w_val;
    end else begin : g_sys
      assign w_a   = SYS_A;
      assign sys_o = w_val;
    end

    always_comb begin
      w_val = r_regs[w_a];
      if (w_a == '0)                           w_val = '0;
      else if (w_wr_hit && (wr_addr_i == w_a)) w_val = w_wr_val;
      else if (w_lk_hit && (LINK_A == w_a))    w_val = lk_data_i;
    end
  end

  reg_scoreboard #(
    .NREGS   (NREGS),
    .CNT_W   (CNT_W),
    .NREAD   (NREAD),
    .LINK_REG(LINK_REG)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .wr_en_i    (wr_en_i),
    .wr_addr_i  (wr_addr_i),
    .lk_en_i    (lk_en_i),
    .iss_valid_i(iss_valid_i),
    .iss_addr_i (iss_addr_i),
    .rd_addr_i  (rd_addr_i),
    .iss_ready_o(iss_ready_o),
    .rd_busy_o  (rd_busy_o)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: expectations queued at drive time, popped and
// compared mid-cycle, one line per transaction.
module tb_regfile_mp;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NREAD = 2;
  localparam int AW    = 5;
  localparam int NB    = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREAD*AW-1:0]   rd_addr_i;
  logic [NREAD*XLEN-1:0] rd_data_o;
  logic [NREAD-1:0]      rd_busy_o;
  logic                  wr_en_i;
  logic [AW-1:0]         wr_addr_i;
  logic [NB-1:0]         wr_be_i;
  logic [XLEN-1:0]       wr_data_i;
  logic                  lk_en_i;
  logic [XLEN-1:0]       lk_data_i;
  logic                  iss_valid_i;
  logic [AW-1:0]         iss_addr_i;
  logic                  iss_ready_o;
  logic [XLEN-1:0]       sys_o;

  regfile_mp dut (
    .clk(clk), .rst(rst),
    .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o), .rd_busy_o(rd_busy_o),
    .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_be_i(wr_be_i), .wr_data_i(wr_data_i),
    .lk_en_i(lk_en_i), .lk_data_i(lk_data_i),
    .iss_valid_i(iss_valid_i), .iss_addr_i(iss_addr_i), .iss_ready_o(iss_ready_o),
    .sys_o(sys_o)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];

  task automatic exp(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $display("FAIL %s: observed %h but no expectation queued", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e)
      else begin
        n_errors++;
        $error("FAIL %s: observed %h expected %h", tag, obs, e);
      end
    end
  endtask

  function automatic logic [31:0] rd(input int k);
    return rd_data_o[k*XLEN +: XLEN];
  endfunction

  function automatic logic [31:0] bz(input int k);
    return {31'd0, rd_busy_o[k]};
  endfunction

  task automatic idle();
    rst = 1'b0; wr_en_i = 1'b0; wr_addr_i = '0; wr_be_i = '0; wr_data_i = '0;
    lk_en_i = 1'b0; lk_data_i = '0; iss_valid_i = 1'b0; iss_addr_i = '0;
  endtask

  task automatic next();
    @(negedge clk);
    idle();
  endtask

  task automatic raddr(input int a0, input int a1);
    rd_addr_i = {AW'(a1), AW'(a0)};
  endtask

  task automatic wr(input int a, input logic [3:0] be, input logic [31:0] d);
    wr_en_i = 1'b1; wr_addr_i = AW'(a); wr_be_i = be; wr_data_i = d;
  endtask

  task automatic iss(input int a);
    iss_valid_i = 1'b1; iss_addr_i = AW'(a);
  endtask

  initial begin
    idle();
    raddr(0, 0);
    rst = 1'b1;
    @(posedge clk);

    // Reset state across every address.
    for (int a = 0; a < NREGS; a++) begin
      next(); raddr(a, NREGS-1-a); iss_addr_i = AW'(a);
      exp(0); exp(0); exp(0); exp(0); exp(1); exp(0);
      #2;
      chk("rst_rd0", rd(0)); chk("rst_rd1", rd(1));
      chk("rst_busy0", bz(0)); chk("rst_busy1", bz(1));
      chk("rst_ready", {31'd0, iss_ready_o}); chk("rst_sys", sys_o);
      $display("reset read a=%0d/%0d -> %h %h busy=%b ready=%b", a, NREGS-1-a,
               rd(0), rd(1), rd_busy_o, iss_ready_o);
    end

    // Full write then byte merge on r5, with bypass.
    next(); raddr(5, 0); wr(5, 4'b1111, 32'h11223344); exp(32'h11223344); #2;
    chk("wr5_full_bypass", rd(0));
    $display("wr r5 be=1111 -> bypass %h", rd(0));
    next(); raddr(5, 0); wr(5, 4'b0010, 32'h0000AB00); exp(32'h1122AB44); #2;
    chk("wr5_merge_bypass", rd(0));
    $display("wr r5 be=0010 -> bypass %h", rd(0));
    next(); raddr(0, 5); exp(32'h1122AB44); #2;
    chk("wr5_stored", rd(1));
    $display("rd r5 -> %h", rd(1));
    next(); raddr(5, 0); wr(5, 4'b0000, 32'hFFFFFFFF); exp(32'h1122AB44); #2;
    chk("wr5_pure_commit", rd(0));
    $display("commit r5 be=0000 -> %h", rd(0));

    // Link and port-0 collision on r31.
    next(); raddr(31, 0); wr(31, 4'b0001, 32'hFFFFFFFF);
    lk_en_i = 1'b1; lk_data_i = 32'h00400010; exp(32'h004000FF); #2;
    chk("lk_collide_bypass", rd(0));
    $display("lk+wr r31 -> bypass %h", rd(0));
    next(); raddr(0, 31); exp(32'h004000FF); #2;
    chk("lk_collide_stored", rd(1));
    $display("rd r31 -> %h", rd(1));

    // Unscoreboarded write to SYS_REG.
    next(); raddr(2, 0); wr(2, 4'b1111, 32'hCAFEF00D); exp(32'hCAFEF00D); exp(0); #2;
    chk("sys_bypass", sys_o); chk("sys_busy", bz(0));
    $display("wr r2 -> sys_o %h busy=%b", sys_o, rd_busy_o[0]);
    next(); raddr(2, 0); exp(32'hCAFEF00D); exp(32'hCAFEF00D); #2;
    chk("sys_stored", sys_o); chk("sys_rd", rd(0));
    $display("rd r2 -> %h sys_o %h", rd(0), sys_o);

    // Fill r7 to max count, then drain.
    for (int i = 0; i < 4; i++) begin
      next(); raddr(7, 0); iss(7);
      exp((i < 3) ? 1 : 0); exp((i == 0) ? 0 : 1); #2;
      chk("iss7_ready", {31'd0, iss_ready_o}); chk("iss7_busy", bz(0));
      $display("issue r7 #%0d -> ready=%b busy=%b", i, iss_ready_o, rd_busy_o[0]);
    end
    next(); raddr(7, 0); wr(7, 4'b1111, 32'hA5A5A5A5); exp(1); exp(32'hA5A5A5A5); #2;
    chk("cm7_1_busy", bz(0)); chk("cm7_1_data", rd(0));
    $display("commit r7 #1 -> busy=%b data %h", rd_busy_o[0], rd(0));
    next(); raddr(7, 0); wr(7, 4'b0000, 32'h0); exp(1); exp(32'hA5A5A5A5); #2;
    chk("cm7_2_busy", bz(0)); chk("cm7_2_data", rd(0));
    $display("commit r7 #2 -> busy=%b data %h", rd_busy_o[0], rd(0));
    next(); raddr(7, 0); wr(7, 4'b0000, 32'h0); exp(0); #2;
    chk("cm7_3_busy", bz(0));
    $display("commit r7 #3 -> busy=%b", rd_busy_o[0]);
    next(); raddr(7, 0); iss_addr_i = AW'(7); exp(0); exp(1); #2;
    chk("r7_idle_busy", bz(0)); chk("r7_idle_ready", {31'd0, iss_ready_o});
    $display("idle r7 -> busy=%b ready=%b", rd_busy_o[0], iss_ready_o);

    // r0 is hardwired to zero and never counted.
    next(); raddr(0, 0); iss(0); wr(0, 4'b1111, 32'hDEADBEEF); exp(1); exp(0); exp(0); #2;
    chk("r0_ready", {31'd0, iss_ready_o}); chk("r0_bypass", rd(0)); chk("r0_busy", bz(0));
    $display("issue+wr r0 -> ready=%b data %h busy=%b", iss_ready_o, rd(0), rd_busy_o[0]);
    next(); raddr(0, 0); exp(0); exp(0); #2;
    chk("r0_stored", rd(0)); chk("r0_busy_after", bz(0));
    $display("rd r0 -> %h busy=%b", rd(0), rd_busy_o[0]);

    // Reset mid-sequence with r9 pending and a concurrent commit.
    next(); raddr(9, 5); iss(9); #2;
    $display("issue r9");
    next(); raddr(9, 5); iss(9); wr(9, 4'b1111, 32'h12345678); rst = 1'b1; #2;
    $display("rst with commit r9");
    next(); raddr(9, 5); exp(0); exp(0); exp(0); exp(0); #2;
    chk("rst9_data", rd(0)); chk("rst9_busy", bz(0)); chk("rst_r5", rd(1)); chk("rst_sys2", sys_o);
    $display("after rst -> r9 %h busy=%b r5 %h sys %h", rd(0), rd_busy_o[0], rd(1), sys_o);

    // Commit at count 0 must not wrap the counter.
    next(); raddr(9, 0); wr(9, 4'b1111, 32'h0BADF00D); exp(32'h0BADF00D); exp(0); #2;
    chk("sat9_data", rd(0)); chk("sat9_busy", bz(0));
    $display("commit r9 cnt=0 -> %h busy=%b", rd(0), rd_busy_o[0]);
    next(); raddr(9, 0); iss(9); #2;
    $display("issue r9");
    next(); raddr(9, 0); exp(1); #2;
    chk("sat9_busy_one", bz(0));
    $display("r9 after one issue -> busy=%b", rd_busy_o[0]);
    next(); raddr(9, 0); wr(9, 4'b0000, 32'h0); exp(0); exp(32'h0BADF00D); #2;
    chk("sat9_commit_busy", bz(0)); chk("sat9_commit_data", rd(0));
    $display("commit r9 -> busy=%b data %h", rd_busy_o[0], rd(0));

    // Two commits to LINK_REG in one cycle both decrement.
    next(); raddr(31, 0); iss(31); #2;
    next(); raddr(31, 0); iss(31); #2;
    $display("issue r31 x2");
    next(); raddr(31, 0); exp(1); #2;
    chk("lk31_busy", bz(0));
    $display("r31 pending -> busy=%b", rd_busy_o[0]);
    next(); raddr(31, 0); wr(31, 4'b1000, 32'h77000000);
    lk_en_i = 1'b1; lk_data_i = 32'h00001234; exp(0); exp(32'h77001234); #2;
    chk("lk31_dbl_busy", bz(0)); chk("lk31_dbl_data", rd(0));
    $display("lk+wr r31 -> busy=%b data %h", rd_busy_o[0], rd(0));
    next(); raddr(31, 0); exp(0); exp(32'h77001234); #2;
    chk("lk31_after_busy", bz(0)); chk("lk31_after_data", rd(0));
    $display("rd r31 -> busy=%b data %h", rd_busy_o[0], rd(0));

    n_checks++;
    assert (exp_q.size() == 0)
    else begin
      n_errors++;
      $error("FAIL scoreboard_drain: observed %0d leftover expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file for the 5-stage MIPS pipeline, sitting between Decode (reads, issue) and WriteBack (commits). Stores NREGS×XLEN architectural registers with clocked writes, byte-enable merge writes for partial loads (LB/LH/LWL/LWR style), and a dedicated link-register write port. Read ports have same-cycle write-to-read bypass. A per-register pending-write scoreboard lets Decode stall on hazards without external bookkeeping.

## Interface
Parameters:
- XLEN, 32: register width in bits; multiple of 8.
- NREGS, 32: number of registers; power of two, ≥ 4.
- NREAD, 2: number of read ports.
- CNT_W, 2: scoreboard counter width per register; max outstanding writes = 2^CNT_W−1.
- LINK_REG, 31: destination of the link port.
- SYS_REG, 2: register tapped on sys_o.
- Derived: AW = clog2(NREGS), NB = XLEN/8.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- rd_addr_i  in  NREAD*AW  read addresses, port k at [k*AW +: AW].
- rd_data_o  out  NREAD*XLEN  read data, bypassed.
- rd_busy_o  out  NREAD  register has an uncommitted pending write.
- wr_en_i  in  1  WriteBack commit, port 0.
- wr_addr_i  in  AW  WriteBack destination.
- wr_be_i  in  NB  byte enables; a 1 replaces that byte.
- wr_data_i  in  XLEN  byte-aligned write data.
- lk_en_i  in  1  link commit to LINK_REG, full word.
- lk_data_i  in  XLEN  link data (return address).
- iss_valid_i  in  1  Decode issues an instruction that will write iss_addr_i.
- iss_addr_i  in  AW  issued destination.
- iss_ready_o  out  1  issue accepted this cycle.
- sys_o  out  XLEN  bypassed value of SYS_REG.

## Operation
- Storage: reg[0] reads 0 always. Writes to address 0 are dropped and never counted.
- Port-0 write: new = (old & ~mask) | (wr_data_i & mask), where mask expands wr_be_i per byte. wr_be_i = 0 with wr_en_i = 1 is a pure commit: data is unchanged and the counter still decrements.
- Link write: when lk_en_i = 1, reg[LINK_REG] gets lk_data_i in full.
- Same-cycle collision on LINK_REG: port 0 merge is applied over the link value, so port 0 bytes win. Both commits decrement the counter.
- Reads are combinational: rd_data_o[k] = the value reg[addr] will hold after this edge's writes (full bypass, including byte merge). sys_o uses the same rule.
- Scoreboard: one CNT_W-bit counter per register.
  - Issue is accepted when iss_valid_i & iss_ready_o; the accepted issue increments cnt[iss_addr_i].
  - Each commit decrements its register's counter, saturating at 0.
  - Net update per edge: cnt + accepted_issue − commits, clamped to [0, max].
- iss_ready_o = (iss_addr_i == 0) | (cnt[iss_addr_i] != max). It uses registered state only; a same-cycle commit does not raise it. Issue to r0 is always accepted with no count.
- rd_busy_o[k] = (addr ≠ 0) & ((cnt[addr] − commits to addr this cycle) > 0). A same-cycle issue does not set busy.

## Timing
- Write latency: data is visible on rd_data_o combinationally in the commit cycle and held in storage from the next edge.
- Scoreboard latency: an issue accepted at edge N shows rd_busy_o = 1 from cycle N+1. A commit in cycle M clears busy combinationally in cycle M when the count reaches 0.
- Reset, one rst cycle:
  - All registers, including LINK_REG and SYS_REG, and all counters go to 0.
  - After reset: rd_data_o = 0, sys_o = 0, rd_busy_o = 0, iss_ready_o = 1.
- rst has priority over same-cycle writes and issues; those are discarded.
- Commit with cnt = 0 (unscoreboarded write, e.g. syscall result to SYS_REG) is legal: data is written and the counter stays 0.
- Issue at max count is not accepted; Decode must hold iss_valid_i. There is no internal queueing.

## Structure
- Package regfile_pkg holds:
  - default XLEN, NREGS, LINK_REG, SYS_REG;
  - function byte_merge(old, data, be), shared by the storage write and the bypass path.
- Sub-module reg_scoreboard (NREGS, CNT_W) holds the counter array, the issue/commit update, and produces iss_ready_o and per-port busy.
- The top level holds storage, write/merge logic, and NREAD bypass muxes generated per port.

## Test plan
- Reset then read all addresses → 0; iss_ready_o = 1; rd_busy_o = 0.
- wr r5 = 0x11223344 be=1111, next cycle wr r5 data 0x0000AB00 be=0010 → reads 0x1122AB44; bypass shows 0x1122AB44 in the second commit cycle.
- Same cycle: lk_en_i data 0x00400010 and wr r31 data 0xFFFFFFFF be=0001 → r31 = 0x004000FF.
- Issue r7 three times (CNT_W = 2) → iss_ready_o = 0 with iss_addr_i = 7 and busy = 1. Commit r7 three times → busy drops in the third commit cycle.
- Issue r0 and write r0 = 0xDEADBEEF → r0 reads 0, never busy.
- Mid-sequence rst with pending r9 and a concurrent commit → r9 = 0, busy = 0, commit discarded.
